// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the data-memory arbiter of the multi-cycle stack MIPS.
// Contents:
//   ADR_W, DATA_W        default MEM address / data widths (32x8 memory)
//   PORT_FETCH/STACK     port identifiers (fetch = 0, stack push/pop = 1)
//   state_t              arbiter sequencer states (IDLE, ACC)
package mem_arb_pkg;

  localparam int ADR_W  = 5;
  localparam int DATA_W = 8;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_STACK = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational two-way picker used by mem_arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin; without it the stack port
// (port 1) always beats the fetch port (port 0).
// Ports:
//   valid0      in   fetch port request
//   valid1      in   stack port request
//   last_grant  in   port id granted most recently (round-robin only)
//   grant       out  one-hot grant, bit 0 = fetch, bit 1 = stack
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
  // On contention the port that did not win last time goes first; a lone
  // requester always wins regardless of history.
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      if (last_grant == PORT_FETCH) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end
`else
  // History plays no part in fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // The stack port always wins over instruction fetch.
  always_comb begin
    grant = 2'b00;
    if (valid1) begin
      grant = 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single port of the 32x8 data memory MEM between instruction
// fetch (port 0) and stack push/pop (port 1). The winning request is
// registered, MEM is strobed for exactly one cycle, and read data comes back
// with a one-cycle rvalid pulse in the following cycle.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (otherwise the
// stack port has fixed priority and no pointer register exists).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req{0,1}_valid/we/adr/wdata  request from fetch / stack port
//   req{0,1}_ready            request accepted this cycle
//   req{0,1}_rvalid           read data valid pulse for that port
//   rdata                     read data shared by both ports
//   mem_adr, mem_data         MEM address and write data
//   mem_write, mem_read       MEM strobes (only during the access cycle)
//   mem_out                   MEM combinational read data
module mem_arbiter #(
  parameter int ADR_W  = mem_arb_pkg::ADR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADR_W-1:0]  req0_adr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADR_W-1:0]  req1_adr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_out
);
  import mem_arb_pkg::*;

  state_t     state;
  state_t     next_state;
  logic [1:0] grant;
  logic       grant_port;
  logic       take;
  logic       last_grant;
  logic       acc_we;
  logic       acc_port;

  mem_arb_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign grant_port = grant[1];

`ifdef MEM_ARB_RR_EN
  // Round-robin history: remembers who won the last grant. It starts at the
  // stack port so that fetch wins the very first contention after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_STACK;
    end else if (take) begin
      last_grant <= grant_port;
    end
  end
`else
  assign last_grant = PORT_STACK;
`endif

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grants are only handed out from IDLE, so an access cycle always sits
  // between two grants. In ACC the latched direction picks exactly one strobe.
  always_comb begin
    next_state = state;
    take       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          take       = 1'b1;
          req0_ready = grant[0];
          req1_ready = grant[1];
          next_state = ACC;
        end
      end
      ACC: begin
        mem_write  = acc_we;
        mem_read   = !acc_we;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The winner's address and data are latched straight into the MEM-facing
  // registers, which then hold their value until the next grant. A read
  // captures mem_out at the end of ACC and raises the owner's rvalid for the
  // following cycle; a reset during ACC drops the response entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_adr     <= '0;
      mem_data    <= '0;
      acc_we      <= 1'b0;
      acc_port    <= PORT_FETCH;
      rdata       <= '0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
    end else begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      if (take) begin
        acc_port <= grant_port;
        if (grant_port == PORT_STACK) begin
          acc_we   <= req1_we;
          mem_adr  <= req1_adr;
          mem_data <= req1_wdata;
        end else begin
          acc_we   <= req0_we;
          mem_adr  <= req0_adr;
          mem_data <= req0_wdata;
        end
      end
      if ((state == ACC) && !acc_we) begin
        rdata <= mem_out;
        if (acc_port == PORT_STACK) begin
          req1_rvalid <= 1'b1;
        end else begin
          req0_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. It models MEM itself (combinational
// read, write on the rising edge) and predicts every response from the
// arbitration rules at transaction level. Expectations follow MEM_ARB_RR_EN
// when the bench is built with it.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [4:0] req0_adr;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [4:0] req1_adr;
  logic [7:0] req1_wdata;
  logic [7:0] rdata;
  logic [4:0] mem_adr;
  logic [7:0] mem_data;
  logic       mem_write, mem_read;
  logic [7:0] mem_out;

  logic [7:0] mem [32];
  logic       mem_clear;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model_mem [32];
  int         model_last;
  logic [7:0] model_rdata;

  mem_arbiter #(.ADR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_adr(req0_adr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_adr(req1_adr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .rdata(rdata), .mem_adr(mem_adr), .mem_data(mem_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_out(mem_out)
  );

  // 10 ns clock; stimulus changes on the falling edge.
  always #5 clk = ~clk;

  // Behavioural MEM: cleared on request, written on the rising edge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[mem_adr] <= mem_data;
    end
  end
  assign mem_out = mem[mem_adr];

  // Arbitration rule: returns winning port, or -1 if nobody asks.
  function automatic int pick(bit v0, bit v1, int last);
`ifdef MEM_ARB_RR_EN
    if (v0 && v1) return 1 - last;
`else
    if (v1) return 1;
`endif
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_adr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_adr = '0; req1_wdata = '0;
  endtask

  // Leaves the bench right on a falling edge with rst released.
  task automatic do_reset(bit clear_mem);
    @(negedge clk);
    rst = 1; mem_clear = clear_mem; idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0; mem_clear = 0;
    model_last = 1; model_rdata = 8'h00;
    if (clear_mem) for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    do_reset(1);
    #1;
    vectors++; if (mem_adr !== 5'd0) begin miscompares++; $display("[TB] FAIL rst_mem_adr got=%0d exp=0", mem_adr); end
    vectors++; if (mem_data !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_mem_data got=%h exp=00", mem_data); end
    vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_write got=%0b exp=0", mem_write); end
    vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_read got=%0b exp=0", mem_read); end
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_rdata got=%h exp=00", rdata); end
    vectors++; if ({req1_rvalid, req0_rvalid} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_rvalid got=%b exp=00", {req1_rvalid, req0_rvalid}); end
    vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_ready got=%b exp=00", {req1_ready, req0_ready}); end
  endtask

  task automatic test_write_then_read();
    req1_valid = 1; req1_we = 1; req1_adr = 5'd10; req1_wdata = 8'hAA;
    #1;
    vectors++; if ({req1_ready, req0_ready} !== 2'b10) begin miscompares++; $display("[TB] FAIL wr_ready got=%b exp=10", {req1_ready, req0_ready}); end
    model_last = 1;
    @(negedge clk); idle_inputs(); #1;
    vectors++; if ({mem_write, mem_read} !== 2'b10) begin miscompares++; $display("[TB] FAIL wr_strobes got=%b exp=10", {mem_write, mem_read}); end
    vectors++; if (mem_adr !== 5'd10) begin miscompares++; $display("[TB] FAIL wr_adr got=%0d exp=10", mem_adr); end
    vectors++; if (mem_data !== 8'hAA) begin miscompares++; $display("[TB] FAIL wr_data got=%h exp=aa", mem_data); end
    model_mem[10] = 8'hAA;
    @(negedge clk); #1;
    vectors++; if ({req1_rvalid, req0_rvalid, mem_write} !== 3'b000) begin miscompares++; $display("[TB] FAIL wr_no_rvalid got=%b exp=000", {req1_rvalid, req0_rvalid, mem_write}); end
    req0_valid = 1; req0_we = 0; req0_adr = 5'd10;
    #1;
    vectors++; if ({req1_ready, req0_ready} !== 2'b01) begin miscompares++; $display("[TB] FAIL rd_ready got=%b exp=01", {req1_ready, req0_ready}); end
    model_last = 0;
    @(negedge clk); idle_inputs(); #1;
    vectors++; if ({mem_write, mem_read} !== 2'b01) begin miscompares++; $display("[TB] FAIL rd_strobes got=%b exp=01", {mem_write, mem_read}); end
    vectors++; if (mem_adr !== 5'd10) begin miscompares++; $display("[TB] FAIL rd_adr got=%0d exp=10", mem_adr); end
    @(negedge clk); #1;
    vectors++; if ({req1_rvalid, req0_rvalid} !== 2'b01) begin miscompares++; $display("[TB] FAIL rd_rvalid got=%b exp=01", {req1_rvalid, req0_rvalid}); end
    vectors++; if (rdata !== model_mem[10]) begin miscompares++; $display("[TB] FAIL rd_rdata got=%h exp=%h", rdata, model_mem[10]); end
    @(negedge clk); #1;
    vectors++; if ({req0_rvalid, mem_read} !== 2'b00) begin miscompares++; $display("[TB] FAIL rd_pulse_end got=%b exp=00", {req0_rvalid, mem_read}); end
  endtask

  task automatic test_simultaneous();
    logic [4:0] adr_of [2];
    logic [7:0] pre_data [2];
    int w, l;
    adr_of[0] = 5'd0; adr_of[1] = 5'd13;
    pre_data[0] = 8'h5A; pre_data[1] = 8'hF0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req1_valid = 1; req1_we = 1; req1_adr = adr_of[i]; req1_wdata = pre_data[i];
      @(negedge clk); idle_inputs();
      model_mem[adr_of[i]] = pre_data[i];
    end
    do_reset(0);
    req0_valid = 1; req0_we = 0; req0_adr = adr_of[0];
    req1_valid = 1; req1_we = 0; req1_adr = adr_of[1];
    #1;
    w = pick(1, 1, model_last); l = 1 - w;
    vectors++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin miscompares++; $display("[TB] FAIL sim_first_ready got=%b exp_winner=%0d", {req1_ready, req0_ready}, w); end
    model_last = w;
    @(negedge clk);
    if (w == 0) req0_valid = 0; else req1_valid = 0;
    #1;
    vectors++; if (mem_read !== 1'b1 || mem_adr !== adr_of[w]) begin miscompares++; $display("[TB] FAIL sim_first_acc got=%0b/%0d exp=1/%0d", mem_read, mem_adr, adr_of[w]); end
    vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin miscompares++; $display("[TB] FAIL sim_acc_ready got=%b exp=00", {req1_ready, req0_ready}); end
    @(negedge clk); #1;
    vectors++; if (req0_rvalid !== (w == 0) || req1_rvalid !== (w == 1)) begin miscompares++; $display("[TB] FAIL sim_first_rvalid got=%b exp_port=%0d", {req1_rvalid, req0_rvalid}, w); end
    vectors++; if (rdata !== model_mem[adr_of[w]]) begin miscompares++; $display("[TB] FAIL sim_first_rdata got=%h exp=%h", rdata, model_mem[adr_of[w]]); end
    vectors++; if (req0_ready !== (l == 0) || req1_ready !== (l == 1)) begin miscompares++; $display("[TB] FAIL sim_second_ready got=%b exp_winner=%0d", {req1_ready, req0_ready}, l); end
    model_last = l;
    @(negedge clk); idle_inputs(); #1;
    vectors++; if (mem_read !== 1'b1 || mem_adr !== adr_of[l]) begin miscompares++; $display("[TB] FAIL sim_second_acc got=%0b/%0d exp=1/%0d", mem_read, mem_adr, adr_of[l]); end
    @(negedge clk); #1;
    vectors++; if (req0_rvalid !== (l == 0) || req1_rvalid !== (l == 1)) begin miscompares++; $display("[TB] FAIL sim_second_rvalid got=%b exp_port=%0d", {req1_rvalid, req0_rvalid}, l); end
    vectors++; if (rdata !== model_mem[adr_of[l]]) begin miscompares++; $display("[TB] FAIL sim_second_rdata got=%h exp=%h", rdata, model_mem[adr_of[l]]); end
  endtask

  task automatic test_back_to_back();
    int grants[$];
    bit prev_grant, prev_strobe, strobe;
    int w;
    do_reset(0);
    prev_grant = 0; prev_strobe = 0;
    req0_valid = 1; req0_we = 0; req0_adr = 5'($urandom_range(0, 31));
    req1_valid = 1; req1_we = 0; req1_adr = 5'($urandom_range(0, 31));
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      w = prev_grant ? -1 : pick(1, 1, model_last);
      strobe = mem_read | mem_write;
      vectors++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin miscompares++; $display("[TB] FAIL b2b_ready cyc=%0d got=%b exp_winner=%0d", cyc, {req1_ready, req0_ready}, w); end
      vectors++; if (strobe !== prev_grant || (prev_strobe && strobe)) begin miscompares++; $display("[TB] FAIL b2b_acc cyc=%0d got=%0b exp=%0b", cyc, strobe, prev_grant); end
      if (w >= 0) begin model_last = w; grants.push_back(w); end
      prev_grant = (w >= 0); prev_strobe = strobe;
      @(negedge clk);
      if (w == 0) req0_adr = 5'($urandom_range(0, 31));
      if (w == 1) req1_adr = 5'($urandom_range(0, 31));
    end
    vectors++; if (grants.size() != 4) begin miscompares++; $display("[TB] FAIL b2b_grant_count got=%0d exp=4", grants.size()); end
    for (int i = 0; i < grants.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      vectors++; if (grants[i] != (i % 2)) begin miscompares++; $display("[TB] FAIL b2b_order i=%0d got=%0d exp=%0d", i, grants[i], i % 2); end
`else
      vectors++; if (grants[i] != 1) begin miscompares++; $display("[TB] FAIL b2b_order i=%0d got=%0d exp=1", i, grants[i]); end
`endif
    end
    idle_inputs();
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_during_acc();
    do_reset(0);
    req1_valid = 1; req1_we = 1; req1_adr = 5'd4; req1_wdata = 8'h3C;
    #1;
    vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL racc_wr_ready got=%0b exp=1", req1_ready); end
    @(negedge clk); idle_inputs(); rst = 1; #1;
    vectors++; if (mem_write !== 1'b1) begin miscompares++; $display("[TB] FAIL racc_wr_strobe got=%0b exp=1", mem_write); end
    model_mem[4] = 8'h3C;
    @(negedge clk); rst = 0; #1;
    model_last = 1; model_rdata = 8'h00;
    vectors++; if ({mem_write, mem_read, req1_rvalid, req0_rvalid} !== 4'b0000) begin miscompares++; $display("[TB] FAIL racc_wr_after got=%b exp=0000", {mem_write, mem_read, req1_rvalid, req0_rvalid}); end
    vectors++; if (mem_adr !== 5'd0 || mem_data !== 8'h00) begin miscompares++; $display("[TB] FAIL racc_wr_regs got=%0d/%h exp=0/00", mem_adr, mem_data); end
    req0_valid = 1; req0_we = 0; req0_adr = 5'd4;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL racc_idle_ready got=%0b exp=1", req0_ready); end
    model_last = 0;
    @(negedge clk); idle_inputs(); #1;
    @(negedge clk); #1;
    vectors++; if (req0_rvalid !== 1'b1 || rdata !== model_mem[4]) begin miscompares++; $display("[TB] FAIL racc_readback got=%0b/%h exp=1/%h", req0_rvalid, rdata, model_mem[4]); end
    req1_valid = 1; req1_we = 0; req1_adr = 5'd4;
    #1;
    @(negedge clk); idle_inputs(); rst = 1; #1;
    vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("[TB] FAIL racc_rd_strobe got=%0b exp=1", mem_read); end
    @(negedge clk); rst = 0; #1;
    model_last = 1; model_rdata = 8'h00;
    vectors++; if ({req1_rvalid, req0_rvalid} !== 2'b00 || rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL racc_rd_dropped got=%b/%h exp=00/00", {req1_rvalid, req0_rvalid}, rdata); end
    @(negedge clk); #1;
    vectors++; if ({req1_rvalid, req0_rvalid, mem_read} !== 3'b000) begin miscompares++; $display("[TB] FAIL racc_rd_later got=%b exp=000", {req1_rvalid, req0_rvalid, mem_read}); end
  endtask

  task automatic test_drop_valid();
    int w;
    do_reset(0);
    req0_valid = 1; req0_we = 0; req0_adr = 5'd0;
    @(negedge clk); idle_inputs();
    model_last = 0;
    @(negedge clk);
    req1_valid = 1; req1_we = 1; req1_adr = 5'd7; req1_wdata = 8'h55;
    req0_valid = 1; req0_we = 0; req0_adr = 5'd9;
    #1;
    w = pick(1, 1, model_last);
    vectors++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin miscompares++; $display("[TB] FAIL drop_ready got=%b exp_winner=%0d", {req1_ready, req0_ready}, w); end
    model_last = 1;
    @(negedge clk); idle_inputs(); #1;
    vectors++; if (mem_write !== 1'b1 || mem_adr !== 5'd7 || mem_data !== 8'h55) begin miscompares++; $display("[TB] FAIL drop_stack_acc got=%0b/%0d/%h exp=1/7/55", mem_write, mem_adr, mem_data); end
    model_mem[7] = 8'h55;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      vectors++; if ({mem_write, mem_read, req0_ready, req0_rvalid} !== 4'b0000) begin miscompares++; $display("[TB] FAIL drop_no_access i=%0d got=%b exp=0000", i, {mem_write, mem_read, req0_ready, req0_rvalid}); end
    end
  endtask

  task automatic test_random();
    bit have [2];
    bit pwe [2];
    logic [4:0] padr [2];
    logic [7:0] pwd [2];
    bit acc_valid, acc_we, rsp_valid, granted_prev;
    int acc_port, rsp_port, w;
    logic [4:0] acc_adr;
    logic [7:0] acc_wdata, rsp_data;
    do_reset(0);
    acc_valid = 0; rsp_valid = 0; granted_prev = 0;
    acc_we = 0; acc_port = 0; rsp_port = 0; acc_adr = '0; acc_wdata = '0; rsp_data = '0;
    for (int p = 0; p < 2; p++) begin have[p] = 0; pwe[p] = 0; padr[p] = '0; pwd[p] = '0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!have[p] && $urandom_range(0, 1) == 1) begin
          have[p] = 1; pwe[p] = 1'($urandom_range(0, 1));
          padr[p] = 5'($urandom_range(0, 31)); pwd[p] = 8'($urandom_range(0, 255));
        end
      end
      req0_valid = have[0]; req0_we = pwe[0]; req0_adr = padr[0]; req0_wdata = pwd[0];
      req1_valid = have[1]; req1_we = pwe[1]; req1_adr = padr[1]; req1_wdata = pwd[1];
      #1;
      w = granted_prev ? -1 : pick(have[0], have[1], model_last);
      vectors++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin miscompares++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp_winner=%0d", cyc, {req1_ready, req0_ready}, w); end
      vectors++; if (mem_write !== (acc_valid && acc_we) || mem_read !== (acc_valid && !acc_we)) begin miscompares++; $display("[TB] FAIL rnd_strobes cyc=%0d got=%b exp=%b", cyc, {mem_write, mem_read}, {acc_valid && acc_we, acc_valid && !acc_we}); end
      if (acc_valid) begin
        vectors++; if (mem_adr !== acc_adr || (acc_we && mem_data !== acc_wdata)) begin miscompares++; $display("[TB] FAIL rnd_acc cyc=%0d got=%0d/%h exp=%0d/%h", cyc, mem_adr, mem_data, acc_adr, acc_wdata); end
      end
      if (rsp_valid) model_rdata = rsp_data;
      vectors++; if (req0_rvalid !== (rsp_valid && rsp_port == 0) || req1_rvalid !== (rsp_valid && rsp_port == 1)) begin miscompares++; $display("[TB] FAIL rnd_rvalid cyc=%0d got=%b exp_valid=%0b port=%0d", cyc, {req1_rvalid, req0_rvalid}, rsp_valid, rsp_port); end
      vectors++; if (rdata !== model_rdata) begin miscompares++; $display("[TB] FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rdata, model_rdata); end
      rsp_valid = acc_valid && !acc_we;
      if (rsp_valid) begin rsp_port = acc_port; rsp_data = model_mem[acc_adr]; end
      if (acc_valid && acc_we) model_mem[acc_adr] = acc_wdata;
      acc_valid = (w >= 0);
      if (w >= 0) begin
        acc_port = w; acc_we = pwe[w]; acc_adr = padr[w]; acc_wdata = pwd[w];
        have[w] = 0; model_last = w;
      end
      granted_prev = (w >= 0);
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    rst = 1; mem_clear = 1; idle_inputs();
    model_last = 1; model_rdata = 8'h00;
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    $display("[TB] mem_arbiter bench starting");
    test_reset();
    test_write_then_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_during_acc();
    test_drop_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
